// File: rtl/bnn_feature_loader.sv
// bnn_feature_loader
// Collects N quantized features (B bits each) over a valid/ready handshake into
// a shadow register, then transfers the full sample to `data` and holds it for a
// HOLD-cycle compute window. The shadow refills while a window runs, so
// back-to-back samples start with no idle gap.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   in_valid  feature valid
//   in_feat   feature value (B bits)
//   in_ready  loader can accept a feature (combinational: !full && !flush)
//   flush     synchronous abort of the partial fill and of any running window
//   data      packed sample, feature k at data[k*B +: B]
//   start     pulse in the first cycle of a window
//   busy      high for every cycle of a window
//   done      pulse in the last cycle of a window
module bnn_feature_loader #(
  parameter int unsigned N    = 11,
  parameter int unsigned B    = 4,
  parameter int unsigned HOLD = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [B-1:0]     in_feat,
  output logic             in_ready,
  input  logic             flush,
  output logic [N*B-1:0]   data,
  output logic             start,
  output logic             busy,
  output logic             done
);

  localparam int unsigned W  = N * B;
  localparam int unsigned IW = $clog2(N + 1);
  localparam int unsigned CW = $clog2(HOLD + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    shadow_q, shadow_d;
  logic [W-1:0]    data_q, data_d;
  logic            start_q, start_d;

  logic            full;
  logic            last;
  logic            accept;
  logic            xfer;

  // Handshake and window-end decode from registered state.
  always_comb begin
    full     = (idx_q == IW'(N));
    last     = (state_q == S_RUN) && (cnt_q == CW'(HOLD - 1));
    in_ready = !full && !flush;
    accept   = in_valid && in_ready;
    xfer     = full && !flush && ((state_q == S_IDLE) || last);
  end

  // Next-state: flush beats transfer, transfer beats fill/count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    start_d  = 1'b0;

    if (flush) begin
      idx_d   = '0;
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (xfer) begin
      data_d  = shadow_q;
      idx_d   = '0;
      state_d = S_RUN;
      cnt_d   = '0;
      start_d = 1'b1;
    end else begin
      if (accept) begin
        // Decoded write avoids a variable-width part-select index.
        for (int unsigned k = 0; k < N; k++) begin
          if (idx_q == IW'(k)) begin
            shadow_d[k*B +: B] = in_feat;
          end
        end
        idx_d = idx_q + IW'(1);
      end
      if (state_q == S_RUN) begin
        if (last) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      start_q  <= start_d;
    end
  end

  // done still shows in a flush cycle; the window is aborted regardless.
  always_comb begin
    data  = data_q;
    start = start_q;
    busy  = (state_q == S_RUN);
    done  = last;
  end

endmodule

// File: tb/tb_bnn_feature_loader.sv
// Bench for bnn_feature_loader: two instances (HOLD=48 and HOLD=1) share the
// same stimulus; a window-position model predicts every output each cycle.
module tb_bnn_feature_loader;

  localparam int unsigned N  = 11;
  localparam int unsigned B  = 4;
  localparam int unsigned W  = N * B;
  localparam int          H0 = 48;
  localparam int          H1 = 1;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [B-1:0] in_feat;
  logic         flush;

  logic         rdy [2];
  logic         st  [2];
  logic         bs  [2];
  logic         dn  [2];
  logic [W-1:0] dt  [2];

  int n_chk;
  int n_fail;

  bnn_feature_loader #(.N(N), .B(B), .HOLD(H0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_feat(in_feat),
    .in_ready(rdy[0]), .flush(flush), .data(dt[0]),
    .start(st[0]), .busy(bs[0]), .done(dn[0])
  );

  bnn_feature_loader #(.N(N), .B(B), .HOLD(H1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_feat(in_feat),
    .in_ready(rdy[1]), .flush(flush), .data(dt[1]),
    .start(st[1]), .busy(bs[1]), .done(dn[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: features collected so far, position inside the current window
  // (-1 when no window), and the sample last handed to the engine.
  int           fill_m [2];
  int           pos_m  [2];
  logic [B-1:0] sh_m   [2][N];
  logic [W-1:0] data_m [2];

  function automatic int hold_of(input int k);
    return (k == 0) ? H0 : H1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        fill_m[k] = 0;
        pos_m[k]  = -1;
        data_m[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int h;
        h = hold_of(k);
        if (flush) begin
          fill_m[k] = 0;
          pos_m[k]  = -1;
        end else if (fill_m[k] == N && (pos_m[k] < 0 || pos_m[k] == h - 1)) begin
          for (int j = 0; j < N; j++) data_m[k][j*B +: B] = sh_m[k][j];
          fill_m[k] = 0;
          pos_m[k]  = 0;
        end else begin
          if (in_valid && fill_m[k] < N) begin
            sh_m[k][fill_m[k]] = in_feat;
            fill_m[k]++;
          end
          if (pos_m[k] >= 0) pos_m[k] = (pos_m[k] == h - 1) ? -1 : pos_m[k] + 1;
        end
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d in_ready", k), 64'(rdy[k]), 64'(fill_m[k] < N && !flush));
      chk($sformatf("dut%0d start", k),    64'(st[k]),  64'(pos_m[k] == 0));
      chk($sformatf("dut%0d busy", k),     64'(bs[k]),  64'(pos_m[k] >= 0));
      chk($sformatf("dut%0d done", k),     64'(dn[k]),  64'(pos_m[k] == hold_of(k) - 1));
      chk($sformatf("dut%0d data", k),     64'(dt[k]),  64'(data_m[k]));
    end
  end

  // Present one feature and hold it until dut0 accepts it.
  task automatic send(input logic [B-1:0] f);
    int n;
    in_valid = 1'b1;
    in_feat  = f;
    n = 0;
    @(negedge clk);
    while (!rdy[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wait();
    int n;
    n = 0;
    @(negedge clk);
    while (bs[0] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("idle timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
  endtask

  localparam logic [W-1:0] SEQ_1_11 = 44'hBA987654321;
  localparam logic [W-1:0] ALL3     = {11{4'h3}};
  localparam logic [W-1:0] ALL5     = {11{4'h5}};
  localparam logic [W-1:0] ALL9     = {11{4'h9}};
  localparam logic [W-1:0] SEQ_0_10 = 44'hA9876543210;

  initial begin
    int c;
    int dpos;
    int n;
    int seen;
    int nstarts;
    int last_start;
    clk = 1'b0; rst = 1'b0; in_valid = 1'b0; in_feat = '0; flush = 1'b0;
    n_chk = 0; n_fail = 0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset data", 64'(dt[0]), 64'(0));
    chk("reset busy", 64'(bs[0]), 64'(0));
    chk("reset ready", 64'(rdy[0]), 64'(1));
    @(posedge clk); #1 rst = 1'b1;

    // Single sample 1..11.
    for (int i = 1; i <= 11; i++) send(B'(i));
    in_valid = 1'b0;
    @(negedge clk);
    chk("single start early", 64'(st[0]), 64'(0));
    @(negedge clk);
    chk("single start", 64'(st[0]), 64'(1));
    chk("single data", 64'(dt[0]), 64'(SEQ_1_11));
    c = 0; dpos = -1;
    while (bs[0] && c < 200) begin
      if (dn[0]) dpos = c;
      c++;
      @(negedge clk);
    end
    chk("busy length", 64'(c), 64'(48));
    chk("done position", 64'(dpos), 64'(47));
    @(posedge clk); #1;

    // Gapped input.
    for (int i = 1; i <= 11; i++) begin
      send(B'(i));
      in_valid = 1'b0;
      if (i < 11) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    chk("gapped start early", 64'(st[0]), 64'(0));
    @(negedge clk);
    chk("gapped start", 64'(st[0]), 64'(1));
    chk("gapped data", 64'(dt[0]), 64'(SEQ_1_11));
    idle_wait();

    // Prefill: A = all 3, B = all 5 streamed back to back.
    for (int i = 0; i < 22; i++) send((i < 11) ? B'(3) : B'(5));
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!dn[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("prefill done seen", 64'(n < 100), 64'(1));
    chk("prefill backpressure", 64'(rdy[0]), 64'(0));
    chk("prefill data A", 64'(dt[0]), 64'(ALL3));
    @(negedge clk);
    chk("b2b start", 64'(st[0]), 64'(1));
    chk("b2b busy", 64'(bs[0]), 64'(1));
    chk("b2b data B", 64'(dt[0]), 64'(ALL5));
    idle_wait();

    // Flush during fill after 6 features.
    for (int i = 0; i < 6; i++) send(B'(7));
    in_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    for (int i = 0; i < 10; i++) send(B'(9));
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("flush fill no start", 64'(bs[0]), 64'(0));
    end
    @(posedge clk); #1;
    send(B'(9));
    in_valid = 1'b0;
    @(negedge clk);
    chk("refill start early", 64'(st[0]), 64'(0));
    @(negedge clk);
    chk("refill start", 64'(st[0]), 64'(1));
    chk("refill data", 64'(dt[0]), 64'(ALL9));

    // Flush in RUN at cnt==20.
    repeat (20) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush cycle busy", 64'(bs[0]), 64'(1));
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush run busy", 64'(bs[0]), 64'(0));
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (st[0] || dn[0]) seen++;
    end
    chk("flush run quiet", 64'(seen), 64'(0));
    chk("flush keeps data", 64'(dt[0]), 64'(ALL9));
    @(posedge clk); #1;

    // Reset mid-run, then a fresh sample is needed.
    for (int i = 0; i < 11; i++) send(B'(2));
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrun reset busy", 64'(bs[0]), 64'(0));
    chk("midrun reset data", 64'(dt[0]), 64'(0));
    chk("midrun reset ready", 64'(rdy[0]), 64'(1));
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 1; i <= 10; i++) send(B'(i));
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post reset no start", 64'(bs[0]), 64'(0));
    end
    @(posedge clk); #1;
    send(B'(11));
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post reset start", 64'(st[0]), 64'(1));
    chk("post reset data", 64'(dt[0]), 64'(SEQ_1_11));

    // HOLD=1 instance under continuous input.
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    in_valid = 1'b1;
    nstarts = 0; last_start = -1;
    for (int cc = 0; cc < 48; cc++) begin
      in_feat = B'(cc);
      @(negedge clk);
      if (st[1]) begin
        chk("hold1 coincident busy", 64'(bs[1]), 64'(1));
        chk("hold1 coincident done", 64'(dn[1]), 64'(1));
        if (nstarts == 0) begin
          chk("hold1 first start cycle", 64'(cc), 64'(12));
          chk("hold1 first data", 64'(dt[1]), 64'(SEQ_0_10));
        end else begin
          chk("hold1 period", 64'(cc - last_start), 64'(12));
        end
        last_start = cc;
        nstarts++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("hold1 starts", 64'(nstarts), 64'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bnn_feature_loader.md
# bnn_feature_loader

Sequential input stage for the BNN inference tops. It accepts quantized features one per cycle over a valid/ready handshake and assembles N of them into the packed `data` word consumed by the sequential layer engine. It then holds `data` stable for a fixed compute window, pulsing `start` at the beginning and `done` at the end. A shadow buffer lets the next sample fill while the current window runs, so back-to-back samples have no gap.

## Interface
- `N`, 11: features per sample.
- `B`, 4: bits per feature.
- `HOLD`, 48: compute-window length in cycles; must be ≥1.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `in_valid` input 1: feature valid.
- `in_feat` input B: feature value.
- `in_ready` output 1: loader can accept a feature; combinational, equal to `!full && !flush`.
- `flush` input 1: synchronous abort; discards the partial shadow and ends any running window.
- `data` output N*B: packed sample. Feature k occupies `data[k*B +: B]`; feature 0 is the first one accepted.
- `start` output 1: one-cycle pulse in the first cycle of a window.
- `busy` output 1: high for every cycle of the window.
- `done` output 1: one-cycle pulse in the last cycle of the window.

## Operation
- **Shadow register.** N*B bits with index `idx` in 0..N; `full` = (`idx`==N).
- **Handshake.** A feature is accepted when `in_valid && in_ready`. On acceptance, `shadow[idx*B +: B] <= in_feat` and `idx <= idx+1`.
- **Stalls.** `in_valid` gaps stall the fill and lose nothing. `in_feat` is ignored when not accepted.
- **State machine: IDLE and RUN.** Window counter `cnt` has width `$clog2(HOLD+1)`.
- **Transfer condition.** `xfer` = `full && !flush && (state==IDLE || (state==RUN && cnt==HOLD-1))`.
- **On xfer:**
  - `data <= shadow`, `idx <= 0`.
  - `state <= RUN`, `cnt <= 0`.
  - `start <= 1` (registered).
- **RUN with no transfer.**
  - `cnt` increments each cycle.
  - At `cnt==HOLD-1` the next state is IDLE, unless `xfer` is true, which begins a new window immediately.
- **Output decode.**
  - `busy` = (state==RUN).
  - `done` = RUN && `cnt==HOLD-1`, combinational from registered state.
  - `start` is high exactly when RUN && `cnt==0`.
- **HOLD==1.** Every window cycle is both the first and the last: `start` and `done` are both high in it.
- **`data` stability.** `data` changes only on `xfer` and otherwise holds its value, including across IDLE and flush.
- **`flush` (synchronous, highest priority):**
  - `idx <= 0`, `state <= IDLE`, `cnt <= 0`.
  - No acceptance in the flush cycle, because `in_ready` is 0.
  - `data` is unchanged.
  - A `done` that would have fired in the flush cycle still shows combinationally in that cycle. The window is nonetheless counted as aborted.
- **Prefill.** While RUN, the shadow keeps filling. Once it is full, `in_ready` stays 0 until the transfer at window end.

## Timing
- **Reset (`rst`==0, asynchronous):**
  - `idx`=0, state IDLE, `cnt`=0, `data`=0.
  - Outputs: `start`=0, `busy`=0, `done`=0, `in_ready`=1 (when `flush` is low).
- **Reset mid-fill or mid-RUN.** Drops everything immediately. The first edge after release behaves as a fresh IDLE.
- **Fill-to-start latency.**
  - Last feature accepted at edge t.
  - If IDLE, `xfer` occurs at edge t+1.
  - `data` is valid and `start`=1 in the cycle following edge t+1.
- **Window length.** Exactly HOLD cycles of `busy`. `start` is in window cycle 0 and `done` in window cycle HOLD-1.
- **Back-to-back samples.** With a full shadow at `done`, the next window's `start` comes in the cycle immediately after `done`, and `busy` stays high continuously.
- **Sustained throughput.** One sample per max(HOLD, N+1) cycles when `in_valid` is held high.
- **`in_ready` timing.** Drops in the cycle after the N-th acceptance and rises in the cycle after `xfer`.

## Test plan
- **Reset values.** Assert `rst`=0 mid-run, then release → all outputs are at reset values, `in_ready`=1, `data`=0, and nothing fires until N new features arrive.
- **Single sample.** N=11, B=4, HOLD=48; feed features 1..11 on consecutive cycles → `data[3:0]`=1 through `data[43:40]`=11. `start` appears 1 cycle after the last handshake, `busy` lasts 48 cycles, and `done` is in cycle 47 of the window.
- **Gapped input.** Toggle `in_valid` every other cycle → same `data`. `start` appears 1 cycle after the 11th acceptance.
- **Prefill and backpressure.** Stream two samples (A=all 3, B=all 5) continuously →
  - B fills during A's window, then `in_ready`=0 until `done`.
  - B's `start` comes in the cycle right after A's `done`, with `busy` never dropping.
  - `data` switches to all 5s exactly at B's `start`.
- **Flush during fill and during RUN.**
  - Flush after 6 features → `idx` is cleared, and 11 fresh features are needed for the next sample.
  - Flush at `cnt`==20 → `busy` drops next cycle, no `start` or `done` follows, and `data` is retained.
- **HOLD=1 configuration.** `start`, `busy` and `done` are coincident in one cycle. With continuous input, a sample completes every N+1 cycles.
